// File: rtl/tpu_mac_pkg.sv
// Shared encodings for the TPU MAC sequencer: operand data types and FSM states.
package tpu_mac_pkg;

   typedef enum logic [1:0] {
      DT_INT8 = 2'b00,
      DT_FP16 = 2'b01,
      DT_FP32 = 2'b10,
      DT_RSVD = 2'b11
   } data_type_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RESP  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/tpu_mac_sequencer.sv
// TPU MAC sequencer: loads a stationary weight into an external MAC, issues N
// accumulate ops that chain the MAC result back as the partial sum, and returns
// the final sum with a sticky overflow flag. Keeps saturating perf counters.
module tpu_mac_sequencer
   import tpu_mac_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_data_type,
   input  logic [DATA_WIDTH-1:0] cmd_weight,
   input  logic [DATA_WIDTH-1:0] cmd_act,
   input  logic [DATA_WIDTH-1:0] cmd_bias,
   input  logic [CNT_WIDTH-1:0]  cmd_count,
   output logic                  mac_enable,
   output logic [1:0]            mac_data_type,
   output logic                  mac_load_weight,
   output logic                  mac_accumulate,
   output logic [DATA_WIDTH-1:0] mac_a,
   output logic [DATA_WIDTH-1:0] mac_b,
   output logic [DATA_WIDTH-1:0] mac_c,
   input  logic [DATA_WIDTH-1:0] mac_c_out,
   input  logic                  mac_overflow,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_overflow,
   input  logic                  perf_clear,
   output logic [CNT_WIDTH-1:0]  op_count,
   output logic [CNT_WIDTH-1:0]  ovf_count
);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   seq_state_e            state_q, state_d;
   data_type_e            type_q, type_d;
   logic [DATA_WIDTH-1:0] weight_q, weight_d;
   logic [DATA_WIDTH-1:0] act_q, act_d;
   logic [DATA_WIDTH-1:0] bias_q, bias_d;
   logic [CNT_WIDTH-1:0]  rem_q, rem_d;
   logic                  first_q, first_d;
   logic                  op_issued_q, op_issued_d;
   logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic                  res_ovf_q, res_ovf_d;
   logic [CNT_WIDTH-1:0]  op_cnt_q, op_cnt_d;
   logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d;
   logic                  accept;
   logic                  ovf_hit;

   // Next-state and MAC/handshake outputs; everything idles at zero by default.
   always_comb begin
      state_d         = state_q;
      cmd_ready       = 1'b0;
      res_valid       = 1'b0;
      mac_enable      = 1'b0;
      mac_data_type   = 2'b00;
      mac_load_weight = 1'b0;
      mac_accumulate  = 1'b0;
      mac_a           = '0;
      mac_b           = '0;
      mac_c           = '0;
      case (state_q)
         ST_IDLE: begin
            // Held low while reset is asserted so every output reads zero.
            cmd_ready = !rst;
            if (cmd_valid && !rst) begin
               state_d = (cmd_count == '0) ? ST_RESP : ST_LOAD;
            end
         end
         ST_LOAD: begin
            mac_enable      = 1'b1;
            mac_load_weight = 1'b1;
            mac_data_type   = type_q;
            mac_b           = weight_q;
            state_d         = ST_RUN;
         end
         ST_RUN: begin
            mac_enable     = 1'b1;
            mac_accumulate = 1'b1;
            mac_data_type  = type_q;
            mac_a          = act_q;
            mac_b          = weight_q;
            // MAC latency is one cycle, so the previous op's result is live now.
            mac_c          = first_q ? bias_q : mac_c_out;
            if (rem_q == CNT_WIDTH'(1)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign accept  = (state_q == ST_IDLE) && cmd_valid && !rst;
   assign ovf_hit = op_issued_q && mac_overflow;

   // Command capture, op tracking, result capture and perf counters.
   always_comb begin
      type_d      = type_q;
      weight_d    = weight_q;
      act_d       = act_q;
      bias_d      = bias_q;
      rem_d       = rem_q;
      first_d     = (state_q == ST_LOAD);
      op_issued_d = mac_enable;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
      op_cnt_d    = op_cnt_q;
      ovf_cnt_d   = ovf_cnt_q;
      if (accept) begin
         type_d    = data_type_e'(cmd_data_type);
         weight_d  = cmd_weight;
         act_d     = cmd_act;
         bias_d    = cmd_bias;
         rem_d     = cmd_count;
         res_ovf_d = 1'b0;
         if (cmd_count == '0) begin
            res_data_d = cmd_bias;
         end
      end else begin
         if (ovf_hit) begin
            res_ovf_d = 1'b1;
         end
         if (state_q == ST_RUN) begin
            rem_d = rem_q - 1'b1;
         end
         if (state_q == ST_DRAIN) begin
            res_data_d = mac_c_out;
         end
      end
      // A clear outranks any increment landing in the same cycle.
      if (perf_clear) begin
         op_cnt_d  = '0;
         ovf_cnt_d = '0;
      end else begin
         if (state_q == ST_RUN) begin
            op_cnt_d = sat_inc(op_cnt_q);
         end
         if (ovf_hit) begin
            ovf_cnt_d = sat_inc(ovf_cnt_q);
         end
      end
   end

   // State and datapath registers; reset discards any in-flight command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         type_q      <= DT_INT8;
         weight_q    <= '0;
         act_q       <= '0;
         bias_q      <= '0;
         rem_q       <= '0;
         first_q     <= 1'b0;
         op_issued_q <= 1'b0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         op_cnt_q    <= '0;
         ovf_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         weight_q    <= weight_d;
         act_q       <= act_d;
         bias_q      <= bias_d;
         rem_q       <= rem_d;
         first_q     <= first_d;
         op_issued_q <= op_issued_d;
         res_data_q  <= res_data_d;
         res_ovf_q   <= res_ovf_d;
         op_cnt_q    <= op_cnt_d;
         ovf_cnt_q   <= ovf_cnt_d;
      end
   end

   assign res_data     = res_data_q;
   assign res_overflow = res_ovf_q;
   assign op_count     = op_cnt_q;
   assign ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_tpu_mac_sequencer.sv
// Self-checking bench for tpu_mac_sequencer with a behavioural one-cycle MAC.
module tb_tpu_mac_sequencer;
   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_data_type;
   logic [DW-1:0] cmd_weight, cmd_act, cmd_bias;
   logic [CW-1:0] cmd_count;
   logic          mac_enable, mac_load_weight, mac_accumulate;
   logic [1:0]    mac_data_type;
   logic [DW-1:0] mac_a, mac_b, mac_c, mac_c_out;
   logic          mac_overflow;
   logic          res_valid, res_ready, res_overflow;
   logic [DW-1:0] res_data;
   logic          perf_clear;
   logic [CW-1:0] op_count, ovf_count;

   logic          inj_en;
   int            inj_a, inj_b;
   int            ridx;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          ovf;
      int            lat;
      int            en;
   } exp_t;
   exp_t sb[$];

   tpu_mac_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data_type(cmd_data_type),
      .cmd_weight(cmd_weight), .cmd_act(cmd_act), .cmd_bias(cmd_bias), .cmd_count(cmd_count),
      .mac_enable(mac_enable), .mac_data_type(mac_data_type), .mac_load_weight(mac_load_weight),
      .mac_accumulate(mac_accumulate), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
      .mac_c_out(mac_c_out), .mac_overflow(mac_overflow),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_overflow(res_overflow),
      .perf_clear(perf_clear), .op_count(op_count), .ovf_count(ovf_count)
   );

   always #5 clk = ~clk;

   // Behavioural MAC: one-cycle latency, overflow injected on chosen RUN op indices.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mac_c_out    <= '0;
         mac_overflow <= 1'b0;
         ridx         <= 0;
      end else begin
         mac_overflow <= 1'b0;
         if (mac_enable) begin
            if (mac_load_weight) begin
               mac_c_out <= '0;
               ridx      <= 0;
            end else if (mac_accumulate) begin
               mac_c_out    <= mac_c + mac_a * mac_b;
               ridx         <= ridx + 1;
               mac_overflow <= inj_en && (ridx == inj_a || ridx == inj_b);
            end
         end
      end
   end

   task automatic send_cmd(input logic [1:0] t, input logic [DW-1:0] w, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input int n, input logic exp_ovf);
      exp_t e;
      logic [DW-1:0] acc;
      acc = b;
      for (int i = 0; i < n; i++) acc = acc + a * w;
      e.data = acc;
      e.ovf  = exp_ovf;
      e.lat  = (n == 0) ? 1 : n + 3;
      e.en   = (n == 0) ? 0 : n + 1;
      cmd_data_type = t;
      cmd_weight    = w;
      cmd_act       = a;
      cmd_bias      = b;
      cmd_count     = CW'(n);
      cmd_valid     = 1'b1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_at_send: got %b expected 1", cmd_ready);
      end
      sb.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_result(input int budget);
      int   k;
      int   en;
      bit   got;
      exp_t e;
      k = 0; en = 0; got = 0;
      while (k < budget) begin
         @(negedge clk);
         k++;
         if (mac_enable === 1'b1) en++;
         if (res_valid === 1'b1) begin
            got = 1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL res_valid_timeout: got no res_valid within %0d cycles", budget);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got res_data %0d expected no result", res_data);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (k !== e.lat) begin
         errors++;
         $display("FAIL latency: got %0d expected %0d", k, e.lat);
      end
      checks++;
      if (res_data !== e.data) begin
         errors++;
         $display("FAIL res_data: got %0d expected %0d", res_data, e.data);
      end
      checks++;
      if (res_overflow !== e.ovf) begin
         errors++;
         $display("FAIL res_overflow: got %b expected %b", res_overflow, e.ovf);
      end
      checks++;
      if (en !== e.en) begin
         errors++;
         $display("FAIL mac_enable_cycles: got %0d expected %0d", en, e.en);
      end
      if (res_ready === 1'b1) @(negedge clk);
   endtask

   task automatic pulse_perf_clear();
      @(negedge clk);
      perf_clear = 1'b1;
      @(negedge clk);
      perf_clear = 1'b0;
      checks++;
      if (op_count !== '0 || ovf_count !== '0) begin
         errors++;
         $display("FAIL perf_clear: got op=%0d ovf=%0d expected 0 0", op_count, ovf_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (mac_enable !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 || op_count !== '0 ||
          ovf_count !== '0 || mac_a !== '0 || mac_b !== '0 || mac_c !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b vld=%b data=%0d op=%0d expected all 0",
                  mac_enable, res_valid, res_data, op_count);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_basic();
      pulse_perf_clear();
      send_cmd(2'b00, 32'd3, 32'd2, 32'd15, 100, 1'b0);
      wait_result(200);
      checks++;
      if (op_count !== CW'(100)) begin
         errors++;
         $display("FAIL op_count_basic: got %0d expected 100", op_count);
      end
      checks++;
      if (ovf_count !== '0) begin
         errors++;
         $display("FAIL ovf_count_basic: got %0d expected 0", ovf_count);
      end
   endtask

   task automatic test_zero_count();
      send_cmd(2'b01, 32'd5, 32'd9, 32'd7, 0, 1'b0);
      wait_result(10);
      checks++;
      if (op_count !== CW'(100)) begin
         errors++;
         $display("FAIL op_count_zero: got %0d expected 100", op_count);
      end
   endtask

   task automatic test_backpressure();
      int vld_drops;
      vld_drops = 0;
      res_ready = 1'b0;
      send_cmd(2'b10, 32'd4, 32'd5, 32'd10, 3, 1'b0);
      wait_result(20);
      for (int i = 0; i < 10; i++) begin
         cmd_valid = 1'b1;
         cmd_count = '0;
         cmd_bias  = 32'd99;
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data !== 32'd70 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_resp: got vld=%b data=%0d rdy=%b expected 1 70 0",
                     res_valid, res_data, cmd_ready);
         end
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready);
      end
      repeat (3) begin
         @(negedge clk);
         if (res_valid === 1'b1) vld_drops++;
      end
      checks++;
      if (vld_drops !== 0) begin
         errors++;
         $display("FAIL ignored_cmd: got %0d res_valid cycles expected 0", vld_drops);
      end
   endtask

   task automatic test_overflow();
      pulse_perf_clear();
      inj_en = 1'b1; inj_a = 5; inj_b = 9;
      send_cmd(2'b00, 32'd1, 32'd1, 32'd0, 20, 1'b1);
      wait_result(40);
      checks++;
      if (ovf_count !== CW'(2)) begin
         errors++;
         $display("FAIL ovf_count: got %0d expected 2", ovf_count);
      end
      perf_clear = 1'b1;
      send_cmd(2'b00, 32'd2, 32'd2, 32'd1, 12, 1'b1);
      wait_result(30);
      checks++;
      if (ovf_count !== '0 || op_count !== '0) begin
         errors++;
         $display("FAIL clear_vs_ovf: got ovf=%0d op=%0d expected 0 0", ovf_count, op_count);
      end
      perf_clear = 1'b0;
      inj_en = 1'b0;
   endtask

   task automatic test_reset_midrun();
      int ops;
      int vld_seen;
      ops = 0; vld_seen = 0;
      send_cmd(2'b00, 32'd3, 32'd2, 32'd15, 100, 1'b0);
      for (int i = 0; i < 200 && ops < 40; i++) begin
         @(negedge clk);
         if (mac_enable === 1'b1 && mac_accumulate === 1'b1) ops++;
      end
      checks++;
      if (ops !== 40) begin
         errors++;
         $display("FAIL reach_op40: got %0d ops expected 40", ops);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mac_enable !== 1'b0 || mac_accumulate !== 1'b0 || mac_a !== '0 || mac_b !== '0 ||
          mac_c !== '0 || res_valid !== 1'b0 || op_count !== '0 || res_data !== '0) begin
         errors++;
         $display("FAIL async_reset: got en=%b a=%0d op=%0d vld=%b expected all 0",
                  mac_enable, mac_a, op_count, res_valid);
      end
      if (sb.size() > 0) void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      repeat (110) begin
         @(negedge clk);
         if (res_valid === 1'b1) vld_seen++;
      end
      checks++;
      if (vld_seen !== 0) begin
         errors++;
         $display("FAIL discarded_cmd: got %0d res_valid cycles expected 0", vld_seen);
      end
      send_cmd(2'b10, 32'd7, 32'd11, 32'd1, 30, 1'b0);
      wait_result(60);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         send_cmd(2'($urandom_range(0, 2)), DW'($urandom_range(0, 65535)),
                  DW'($urandom_range(0, 65535)), DW'($urandom), $urandom_range(1, 8), 1'b0);
         wait_result(30);
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_data_type = 2'b00; cmd_weight = '0; cmd_act = '0;
      cmd_bias = '0; cmd_count = '0; res_ready = 1'b1; perf_clear = 1'b0;
      inj_en = 1'b0; inj_a = 0; inj_b = 0; rst = 1'b1;
      test_reset();
      test_basic();
      test_zero_count();
      test_backpressure();
      test_overflow();
      test_reset_midrun();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
